// File: rtl/gnr_attractor_ctrl_if.sv
// Host-side run interface of gnr_attractor_ctrl.
// master = host issuing runs, slave = the controller.
interface gnr_attractor_ctrl_if #(
    parameter int NUM_NODES = 8,
    parameter int CNT_W     = 16
);
    logic                 start;
    logic [NUM_NODES-1:0] init_value;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     meet_steps;
    logic [CNT_W-1:0]     period;
    logic [NUM_NODES-1:0] result_state;
    logic                 timeout;

    modport master (
        output start, init_value,
        input  busy, done, meet_steps, period, result_state, timeout
    );

    modport slave (
        input  start, init_value,
        output busy, done, meet_steps, period, result_state, timeout
    );
endinterface

// File: rtl/gnr_attractor_ctrl.sv
// Floyd attractor search sequencer for a GRN node array.
// Optional step limit: define GNR_TIMEOUT_EN.
module gnr_attractor_ctrl #(
    parameter int               NUM_NODES = 8,
    parameter int               CNT_W     = 16,
    parameter logic [CNT_W-1:0] MAX_STEPS = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    gnr_attractor_ctrl_if.slave  run,
    output logic                 reset_nos,
    output logic [NUM_NODES-1:0] init_state,
    output logic                 start_s0,
    output logic                 start_s1,
    input  logic [NUM_NODES-1:0] nos_s0,
    input  logic [NUM_NODES-1:0] nos_s1
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEARCH,
        PERIOD,
        DONE
    } state_t;

`ifdef GNR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     meet_q;
    logic [CNT_W-1:0]     period_q;
    logic [NUM_NODES-1:0] init_q;
    logic [NUM_NODES-1:0] result_q;
    logic                 timeout_q;
    logic                 hit;
    logic                 limit;
    logic                 cnt_max;

    assign cnt_max = &cnt;

    // Both copies coincide trivially after the first step, so mask n<2.
    always_comb begin
        hit = 1'b0;
        unique case (state)
            SEARCH:  hit = (cnt >= CNT_W'(2)) && (nos_s0 == nos_s1);
            PERIOD:  hit = (cnt >= CNT_W'(1)) && (nos_s1 == result_q);
            default: hit = 1'b0;
        endcase
    end

    assign limit = TO_EN
                 && ((state == SEARCH) || (state == PERIOD))
                 && (cnt == MAX_STEPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (run.start) state_nxt = LOAD;
            LOAD:    state_nxt = SEARCH;
            SEARCH: begin
                if (hit)        state_nxt = PERIOD;
                else if (limit) state_nxt = DONE;
            end
            PERIOD:  if (hit || limit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        reset_nos = 1'b0;
        start_s0  = 1'b0;
        start_s1  = 1'b0;
        run.busy  = 1'b0;
        run.done  = 1'b0;
        unique case (state)
            IDLE: ;
            LOAD: begin
                reset_nos = 1'b1;
                run.busy  = 1'b1;
            end
            SEARCH: begin
                start_s0 = !hit && !limit;
                start_s1 = !hit && !limit;
                run.busy = 1'b1;
            end
            PERIOD: begin
                start_s1 = !hit && !limit;
                run.busy = 1'b1;
            end
            DONE: begin
                run.busy = 1'b1;
                run.done = 1'b1;
            end
            default: ;
        endcase
    end

    // One step counter serves both phases; it is cleared on each entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            init_q    <= '0;
            meet_q    <= '0;
            period_q  <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (run.start) begin
                        init_q    <= run.init_value;
                        meet_q    <= '0;
                        period_q  <= '0;
                        result_q  <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                LOAD: cnt <= '0;
                SEARCH: begin
                    if (hit) begin
                        meet_q   <= cnt;
                        result_q <= nos_s1;
                        cnt      <= '0;
                    end else if (limit) begin
                        meet_q    <= cnt;
                        timeout_q <= 1'b1;
                    end else if (!cnt_max) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PERIOD: begin
                    if (hit) begin
                        period_q <= cnt;
                    end else if (limit) begin
                        period_q  <= cnt;
                        timeout_q <= 1'b1;
                    end else if (!cnt_max) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign init_state       = init_q;
    assign run.meet_steps   = meet_q;
    assign run.period       = period_q;
    assign run.result_state = result_q;
    assign run.timeout      = timeout_q;

endmodule
